ws_led_capture: RTL and testbench

WS_LED_CAPTURE -- requirements
Module: ws_led_capture

---
 rtl/ws_led_capture.sv | 128 ++++++++++++
 tb/tb_ws_led_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ws_led_capture.sv
// WS2812 daisy-chain receiver: skips a programmable number of LED words after
// each latch/reset, captures the next word, then passes the rest downstream.
module ws_led_capture #(
    parameter int DATA_W = 24,
    parameter int SKIP_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    input  logic              i_bit,
    input  logic              i_treset,
    input  logic [SKIP_W-1:0] i_skip,
    output logic [DATA_W-1:0] o_led_data,
    output logic              o_data_valid,
    output logic              o_passthru_en,
    output logic [CNT_W-1:0]  o_led_count
);

    localparam int BC_W = $clog2(DATA_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_SKIP     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_PASSTHRU = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SKIP_W-1:0]   led_cnt_q, led_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   led_data_q, led_data_d;
    logic                data_valid_q, data_valid_d;
    logic [CNT_W-1:0]    led_count_q, led_count_d;

    logic                accept;
    logic                word_done;
    logic [SKIP_W-1:0]   led_cnt_inc;

    // A bit coincident with i_treset belongs to no frame and is dropped.
    assign accept      = i_valid & ~i_treset;
    assign word_done   = accept && (bit_cnt_q == LAST_BIT);
    assign led_cnt_inc = led_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        bit_cnt_d    = bit_cnt_q;
        led_cnt_d    = led_cnt_q;
        shift_d      = shift_q;
        led_data_d   = led_data_q;
        data_valid_d = 1'b0;
        led_count_d  = led_count_q;

        if (i_treset) begin
            skip_d      = i_skip;
            bit_cnt_d   = '0;
            led_cnt_d   = '0;
            shift_d     = '0;
            led_count_d = '0;
            state_d     = (i_skip != '0) ? ST_SKIP : ST_CAPTURE;
        end else begin
            if (accept) begin
                bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
            end
            if (word_done && (led_count_q != '1)) begin
                led_count_d = led_count_q + 1'b1;
            end

            case (state_q)
                ST_SKIP: begin
                    if (word_done) begin
                        led_cnt_d = led_cnt_inc;
                        if (led_cnt_inc == skip_q) begin
                            state_d = ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (accept) begin
                        shift_d = {shift_q[DATA_W-2:0], i_bit};
                    end
                    if (word_done) begin
                        led_data_d   = {shift_q[DATA_W-2:0], i_bit};
                        data_valid_d = 1'b1;
                        state_d      = ST_PASSTHRU;
                    end
                end
                ST_PASSTHRU: begin
                    state_d = ST_PASSTHRU;
                end
                default: begin
                    state_d = ST_CAPTURE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_CAPTURE;
            skip_q       <= '0;
            bit_cnt_q    <= '0;
            led_cnt_q    <= '0;
            shift_q      <= '0;
            led_data_q   <= '0;
            data_valid_q <= 1'b0;
            led_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            bit_cnt_q    <= bit_cnt_d;
            led_cnt_q    <= led_cnt_d;
            shift_q      <= shift_d;
            led_data_q   <= led_data_d;
            data_valid_q <= data_valid_d;
            led_count_q  <= led_count_d;
        end
    end

    assign o_led_data    = led_data_q;
    assign o_data_valid  = data_valid_q;
    assign o_led_count   = led_count_q;
    assign o_passthru_en = (state_q == ST_SKIP) || (state_q == ST_PASSTHRU);

endmodule

// File: tb/tb_ws_led_capture.sv
// Testbench for ws_led_capture: directed frames plus randomized traffic,
// checked against a frame-level model of which word this node should own.
module tb_ws_led_capture;

   logic        clk = 1'b0;
   logic        resetN;
   logic        valid, bitIn, treset;
   logic [7:0]  skip;
   logic [23:0] ledData;
   logic        dataValid, passthruEn;
   logic [15:0] ledCount;

   logic        valid2, bit2, treset2;
   logic [7:0]  skip2;
   logic [31:0] ledData2;
   logic        dataValid2, passthruEn2;
   logic [1:0]  ledCount2;

   int checkCount = 0;
   int errorCount = 0;
   int pulses2 = 0;

   // Model state: words seen this frame, bits into the current word, and
   // whether this node has already taken its word.
   int          mSkip, mWords, mBits;
   logic [23:0] mAcc, mLedData;
   bit          mCaptured, mValid;

   ws_led_capture #(.DATA_W(24), .SKIP_W(8), .CNT_W(16)) dut (
      .i_clk(clk), .i_reset_n(resetN), .i_valid(valid), .i_bit(bitIn),
      .i_treset(treset), .i_skip(skip), .o_led_data(ledData),
      .o_data_valid(dataValid), .o_passthru_en(passthruEn), .o_led_count(ledCount)
   );

   ws_led_capture #(.DATA_W(32), .SKIP_W(8), .CNT_W(2)) dutWide (
      .i_clk(clk), .i_reset_n(resetN), .i_valid(valid2), .i_bit(bit2),
      .i_treset(treset2), .i_skip(skip2), .o_led_data(ledData2),
      .o_data_valid(dataValid2), .o_passthru_en(passthruEn2), .o_led_count(ledCount2)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Counts capture pulses of the wide instance, sampled away from the edge
   always @(negedge clk) begin
      if (dataValid2 === 1'b1) pulses2++;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      mSkip = 0; mWords = 0; mBits = 0; mAcc = '0; mLedData = '0;
      mCaptured = 0; mValid = 0;
   endtask

   // Node owns word number mSkip (0-based) of each frame
   task automatic modelStep(input logic v, input logic b, input logic t, input logic [7:0] s);
      mValid = 0;
      if (t) begin
         mSkip = int'(s); mWords = 0; mBits = 0; mAcc = '0; mCaptured = 0;
      end else if (v) begin
         mAcc = {mAcc[22:0], b};
         mBits++;
         if (mBits == 24) begin
            mBits = 0;
            if (!mCaptured && mWords == mSkip) begin
               mLedData = mAcc; mValid = 1; mCaptured = 1;
            end
            mWords++;
         end
      end
   endtask

   task automatic compareAll();
      int expCount;
      expCount = (mWords > 65535) ? 65535 : mWords;
      checkOutput("ledData", 64'(ledData), 64'(mLedData));
      checkOutput("dataValid", 64'(dataValid), 64'(mValid));
      checkOutput("passthruEn", 64'(passthruEn), 64'(mCaptured || (mWords < mSkip)));
      checkOutput("ledCount", 64'(ledCount), 64'(expCount));
   endtask

   // One clock of stimulus on the 24-bit instance, then compare with the model
   task automatic applyStimulus(input logic v, input logic b, input logic t, input logic [7:0] s);
      @(negedge clk);
      valid = v; bitIn = b; treset = t; skip = s;
      @(posedge clk);
      modelStep(v, b, t, s);
      #1;
      compareAll();
   endtask

   task automatic applyStimulus2(input logic v, input logic b, input logic t);
      @(negedge clk);
      valid2 = v; bit2 = b; treset2 = t; skip2 = 8'd0;
      @(posedge clk);
   endtask

   task automatic sendWord(input logic [23:0] w, input bit gaps);
      for (int i = 23; i >= 0; i--) begin
         if (gaps && $urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
         applyStimulus(1'b1, w[i], 1'b0, 8'd0);
      end
   endtask

   task automatic hitReset();
      valid = 0; bitIn = 0; treset = 0;
      resetN = 1'b0;
      #2;
      checkOutput("rstLedData", 64'(ledData), 64'd0);
      checkOutput("rstDataValid", 64'(dataValid), 64'd0);
      checkOutput("rstLedCount", 64'(ledCount), 64'd0);
      checkOutput("rstPassthru", 64'(passthruEn), 64'd0);
      modelReset();
      @(negedge clk);
      resetN = 1'b1;
   endtask

   initial begin
      logic [31:0] wideWord;
      int nBits;
      logic [7:0] s;

      valid = 0; bitIn = 0; treset = 0; skip = 0;
      valid2 = 0; bit2 = 0; treset2 = 0; skip2 = 0;
      resetN = 1'b0;
      modelReset();
      #12;
      checkOutput("initLedData", 64'(ledData), 64'd0);
      checkOutput("initPassthru", 64'(passthruEn), 64'd0);
      checkOutput("initLedCount", 64'(ledCount), 64'd0);
      @(negedge clk);
      resetN = 1'b1;

      // Out of reset the node behaves as skip 0 without any i_treset
      sendWord(24'h5A5A5A, 1'b0);
      checkOutput("noTresetData", 64'(ledData), 64'h5A5A5A);

      // Basic capture, then a second word passes through
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
      sendWord(24'hA5C3F0, 1'b0);
      checkOutput("basicData", 64'(ledData), 64'hA5C3F0);
      checkOutput("basicPulse", 64'(dataValid), 64'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
      checkOutput("basicPulseEnd", 64'(dataValid), 64'd0);
      sendWord(24'h0F0F0F, 1'b1);
      checkOutput("basicHold", 64'(ledData), 64'hA5C3F0);
      checkOutput("basicCount", 64'(ledCount), 64'd2);

      // Skip two words, capture the third
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd2);
      sendWord(24'h111111, 1'b0);
      sendWord(24'h222222, 1'b0);
      checkOutput("skipPassthruOff", 64'(passthruEn), 64'd0);
      sendWord(24'h333333, 1'b0);
      checkOutput("skipData", 64'(ledData), 64'h333333);
      checkOutput("skipCount", 64'(ledCount), 64'd3);
      checkOutput("skipPassthruOn", 64'(passthruEn), 64'd1);

      // Partial word at frame start is discarded
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
      sendWord(24'h00FF00, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
      checkOutput("partialHold", 64'(ledData), 64'h00FF00);
      sendWord(24'h123456, 1'b1);
      checkOutput("partialNext", 64'(ledData), 64'h123456);

      // Bit coincident with i_treset must be dropped
      applyStimulus(1'b1, 1'b1, 1'b1, 8'd0);
      sendWord(24'h000001, 1'b0);
      checkOutput("coincidentData", 64'(ledData), 64'h000001);

      // Async reset in PASSTHRU after bit 30, then capture without i_treset
      applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
      sendWord(24'hABCDEF, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
      hitReset();
      sendWord(24'hC0FFEE, 1'b1);
      checkOutput("afterResetData", 64'(ledData), 64'hC0FFEE);

      // Randomized frames; i_skip garbage on non-treset cycles must be ignored
      for (int f = 0; f < 25; f++) begin
         s = 8'($urandom_range(0, 3));
         applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1, s);
         nBits = $urandom_range(0, 5) * 24 + $urandom_range(0, 23);
         for (int i = 0; i < nBits; i++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom));
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
         end
      end

      // Wide word and saturating counter on the 32-bit instance
      wideWord = 32'hDEADBEEF;
      pulses2 = 0;
      applyStimulus2(1'b0, 1'b0, 1'b1);
      for (int i = 31; i >= 0; i--) applyStimulus2(1'b1, wideWord[i], 1'b0);
      for (int i = 0; i < 4 * 32; i++) applyStimulus2(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      applyStimulus2(1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("wideData", 64'(ledData2), 64'hDEADBEEF);
      checkOutput("wideCount", 64'(ledCount2), 64'd3);
      checkOutput("widePassthru", 64'(passthruEn2), 64'd1);
      @(negedge clk);
      checkOutput("widePulses", 64'(pulses2), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
